// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared FSM state type and width helper for the interrupt controller
package intr_ctrl_pkg;
    typedef enum logic {IDLE, SERVICE} state_t;
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/intr_arbiter.sv
// intr_arbiter: combinational fixed-priority (highest index) or round-robin pick
module intr_arbiter #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] rr_ptr,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           valid
);
    logic [IDW-1:0] fix_w;
    logic [IDW-1:0] rr_w;
    // Later assignments win: ascending scan keeps the highest index, descending
    // offset scan keeps the first hit at or above rr_ptr.
    always_comb begin
        fix_w = '0;
        rr_w  = '0;
        for (int i = 0; i < N; i++)
            if (eligible[i]) fix_w = IDW'(i);
        for (int k = N - 1; k >= 0; k--)
            if (eligible[IDW'((int'(rr_ptr) + k) % N)]) rr_w = IDW'((int'(rr_ptr) + k) % N);
    end
    assign winner = mode ? rr_w : fix_w;
    assign valid  = |eligible;
endmodule

// File: rtl/intr_controller_arb.sv
// intr_controller_arb: level/edge interrupt collector with one-at-a-time grant,
// done handshake and optional service timeout
module intr_controller_arb
    import intr_ctrl_pkg::*;
#(
    parameter int               NINTR     = 8,
    parameter logic [NINTR-1:0] EDGE_MASK = '0,
    parameter int               RR_MODE   = 0,
    parameter int               TIMEOUT   = 0,
    parameter int               IDW       = $clog2(NINTR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NINTR-1:0] req,
    input  logic [NINTR-1:0] mask,
    input  logic             done,
    output logic             irq,
    output logic [NINTR-1:0] ack,
    output logic [IDW-1:0]   id,
    output logic             err,
    output logic [NINTR-1:0] pending
);
    localparam int TW = safe_clog2(TIMEOUT + 1);
    state_t           state;
    logic [NINTR-1:0] req_q;
    logic [NINTR-1:0] edge_pend;
    logic [NINTR-1:0] rise;
    logic [NINTR-1:0] eligible;
    logic [NINTR-1:0] clr;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic             valid;
    logic [TW-1:0]    tmo_cnt;
    logic             tmo_hit;
    logic             leave;
    assign rise     = req & ~req_q & EDGE_MASK;
    assign eligible = mask & (((edge_pend | rise) & EDGE_MASK) | (req & ~EDGE_MASK));
    assign pending  = edge_pend | (req & ~EDGE_MASK);
    assign tmo_hit  = (TIMEOUT > 0) && (tmo_cnt == TW'(TIMEOUT - 1));
    assign leave    = (state == SERVICE) && (done || tmo_hit);
    // The granted channel's latch clears on exit; a same-cycle rise re-sets it.
    assign clr      = leave ? ack : '0;
    intr_arbiter #(.N(NINTR), .IDW(IDW)) u_arb (
        .eligible(eligible),
        .rr_ptr  (rr_ptr),
        .mode    (RR_MODE != 0),
        .winner  (winner),
        .valid   (valid)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq       <= 1'b0;
            ack       <= '0;
            id        <= '0;
            err       <= 1'b0;
            edge_pend <= '0;
            req_q     <= '1;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
        end else begin
            req_q     <= req;
            edge_pend <= (edge_pend & ~clr) | rise;
            err       <= leave && !done;
            if (state == IDLE && valid) begin
                state   <= SERVICE;
                irq     <= 1'b1;
                ack     <= NINTR'(1) << winner;
                id      <= winner;
                tmo_cnt <= '0;
                if (RR_MODE != 0)
                    rr_ptr <= (winner == IDW'(NINTR - 1)) ? '0 : winner + 1'b1;
            end else if (state == SERVICE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (leave) begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    ack   <= '0;
                    id    <= '0;
                end
            end
        end
    end
endmodule
